// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and tone-index constants for the music-player datapath
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_HOLD,
        ST_PAUSED
    } seq_state_e;

    localparam int              INX_W         = 4;
    localparam logic [INX_W-1:0] REST_INX      = 4'd0;
    localparam logic [INX_W-1:0] HIGH_OCT_BASE = 4'd8;

endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - beat counter with clear, count-enable and terminal count
module beat_timer #(
    parameter int BEAT_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(BEAT_DIV) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CW'(BEAT_DIV - 1));

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - note-ROM playback FSM with manual key override driving tone index INX
module music_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 138,
    parameter int BEAT_DIV  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MODE,
    input  logic [INX_W-1:0]  KEY_INX,
    input  logic              PLAY,
    input  logic              PAUSE,
    input  logic              STOP,
    input  logic              LOOP,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [INX_W-1:0]  ROM_DATA,
    output logic [INX_W-1:0]  INX,
    output logic              PLAYING,
    output logic              SONG_END
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_ADDR);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pointer_q, pointer_d;
    logic [INX_W-1:0]  inx_q, inx_d;
    logic              song_end;
    logic              beat_en;
    logic              beat_tc;

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        inx_d     = inx_q;
        song_end  = 1'b0;

        if (MODE) begin
            state_d   = ST_IDLE;
            pointer_d = '0;
            inx_d     = KEY_INX;
        end else if (STOP) begin
            state_d   = ST_IDLE;
            pointer_d = '0;
            inx_d     = REST_INX;
        end else begin
            unique case (state_q)
                // Resting in IDLE also clears the key value left over from manual mode.
                ST_IDLE: begin
                    inx_d = REST_INX;
                    if (PLAY) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSED;
                        inx_d   = REST_INX;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSED;
                        inx_d   = REST_INX;
                    end else begin
                        state_d = ST_HOLD;
                        inx_d   = ROM_DATA;
                    end
                end
                ST_HOLD: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSED;
                        inx_d   = REST_INX;
                    end else if (beat_tc) begin
                        if (pointer_q < LAST_PTR) begin
                            pointer_d = pointer_q + ADDR_W'(1);
                            state_d   = ST_FETCH;
                        end else begin
                            song_end  = 1'b1;
                            pointer_d = '0;
                            if (LOOP) begin
                                state_d = ST_FETCH;
                            end else begin
                                state_d = ST_IDLE;
                                inx_d   = REST_INX;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (PLAY) state_d = ST_FETCH;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            pointer_q <= '0;
            inx_q     <= REST_INX;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            inx_q     <= inx_d;
        end
    end

    // Counter runs only while HOLD continues, so every fresh HOLD starts at count 0.
    assign beat_en = (state_q == ST_HOLD) && (state_d == ST_HOLD);

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk   (CLK),
        .rst_n (RST_N),
        .clear (!beat_en),
        .en    (beat_en),
        .tc    (beat_tc)
    );

    assign ROM_ADDR = pointer_q;
    assign INX      = inx_q;
    assign SONG_END = song_end;
    assign PLAYING  = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - directed self-checking bench for music_sequencer
module tb_music_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       MODE = 1'b0;
    logic [3:0] KEY_INX = 4'd0;
    logic       PLAY = 1'b0;
    logic       PAUSE = 1'b0;
    logic       STOP = 1'b0;
    logic       LOOP = 1'b0;
    logic [7:0] ROM_ADDR;
    logic [3:0] ROM_DATA = 4'd0;
    logic [3:0] INX;
    logic       PLAYING;
    logic       SONG_END;

    int vectors = 0;
    int miscompares = 0;

    music_sequencer #(
        .ADDR_W    (8),
        .LAST_ADDR (3),
        .BEAT_DIV  (4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .MODE     (MODE),
        .KEY_INX  (KEY_INX),
        .PLAY     (PLAY),
        .PAUSE    (PAUSE),
        .STOP     (STOP),
        .LOOP     (LOOP),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA),
        .INX      (INX),
        .PLAYING  (PLAYING),
        .SONG_END (SONG_END)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] rom_val(input int a);
        case (a)
            0: rom_val = 4'd5;
            1: rom_val = 4'd5;
            2: rom_val = 4'd9;
            default: rom_val = 4'd0;
        endcase
    endfunction

    always @(posedge CLK) ROM_DATA <= rom_val(int'(ROM_ADDR));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_play;
        PLAY = 1'b1;
        tick();
        PLAY = 1'b0;
    endtask

    task automatic pulse_pause;
        PAUSE = 1'b1;
        tick();
        PAUSE = 1'b0;
    endtask

    task automatic pulse_stop;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        vectors++; if (INX !== 4'd0) begin miscompares++; $display("FAIL reset_inx got %0d want 0", INX); end
        vectors++; if (ROM_ADDR !== 8'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", ROM_ADDR); end
        vectors++; if (PLAYING !== 1'b0) begin miscompares++; $display("FAIL reset_playing got %b want 0", PLAYING); end
        vectors++; if (SONG_END !== 1'b0) begin miscompares++; $display("FAIL reset_song_end got %b want 0", SONG_END); end
        RST_N = 1'b1;
        tick();
        vectors++; if (PLAYING !== 1'b0) begin miscompares++; $display("FAIL reset_idle got %b want 0", PLAYING); end
    endtask

    task automatic test_basic_play;
        int ends;
        logic [3:0] e_inx;
        logic [7:0] e_addr;
        ends = 0;
        LOOP = 1'b0;
        pulse_play();
        for (int n = 1; n <= 26; n++) begin
            if (n > 1) tick();
            e_inx  = (n < 3 || n > 24) ? 4'd0 : rom_val((n - 3) / 6);
            e_addr = (n <= 24) ? 8'((n - 1) / 6) : 8'd0;
            if (SONG_END === 1'b1) ends++;
            vectors++; if (INX !== e_inx) begin miscompares++; $display("FAIL basic_inx n=%0d got %0d want %0d", n, INX, e_inx); end
            vectors++; if (ROM_ADDR !== e_addr) begin miscompares++; $display("FAIL basic_addr n=%0d got %0d want %0d", n, ROM_ADDR, e_addr); end
            vectors++; if (PLAYING !== (n <= 24)) begin miscompares++; $display("FAIL basic_playing n=%0d got %b want %b", n, PLAYING, (n <= 24)); end
            vectors++; if (SONG_END !== (n == 24)) begin miscompares++; $display("FAIL basic_song_end n=%0d got %b want %b", n, SONG_END, (n == 24)); end
        end
        vectors++; if (ends != 1) begin miscompares++; $display("FAIL basic_end_count got %0d want 1", ends); end
    endtask

    task automatic test_loop;
        int ends;
        int m;
        logic [3:0] e_inx;
        ends = 0;
        LOOP = 1'b1;
        pulse_play();
        for (int n = 1; n <= 48; n++) begin
            if (n > 1) tick();
            m = (n - 1) % 24 + 1;
            e_inx = (m < 3) ? 4'd0 : rom_val((m - 3) / 6);
            if (SONG_END === 1'b1) ends++;
            vectors++; if (INX !== e_inx) begin miscompares++; $display("FAIL loop_inx n=%0d got %0d want %0d", n, INX, e_inx); end
            vectors++; if (ROM_ADDR !== 8'((m - 1) / 6)) begin miscompares++; $display("FAIL loop_addr n=%0d got %0d want %0d", n, ROM_ADDR, (m - 1) / 6); end
            vectors++; if (PLAYING !== 1'b1) begin miscompares++; $display("FAIL loop_playing n=%0d got %b want 1", n, PLAYING); end
        end
        vectors++; if (ends != 2) begin miscompares++; $display("FAIL loop_end_count got %0d want 2", ends); end
        LOOP = 1'b0;
        pulse_stop();
        vectors++; if (PLAYING !== 1'b0 || ROM_ADDR !== 8'd0 || INX !== 4'd0) begin
            miscompares++; $display("FAIL loop_stop got playing=%b addr=%0d inx=%0d want 0/0/0", PLAYING, ROM_ADDR, INX);
        end
    endtask

    task automatic test_pause_resume;
        pulse_play();
        repeat (15) tick();
        vectors++; if (INX !== 4'd9) begin miscompares++; $display("FAIL pause_pre_inx got %0d want 9", INX); end
        pulse_pause();
        vectors++; if (INX !== 4'd0) begin miscompares++; $display("FAIL pause_inx got %0d want 0", INX); end
        vectors++; if (ROM_ADDR !== 8'd2) begin miscompares++; $display("FAIL pause_addr got %0d want 2", ROM_ADDR); end
        vectors++; if (PLAYING !== 1'b0) begin miscompares++; $display("FAIL pause_playing got %b want 0", PLAYING); end
        repeat (10) tick();
        vectors++; if (INX !== 4'd0 || ROM_ADDR !== 8'd2) begin miscompares++; $display("FAIL pause_hold got inx=%0d addr=%0d want 0/2", INX, ROM_ADDR); end
        pulse_play();
        vectors++; if (PLAYING !== 1'b1 || ROM_ADDR !== 8'd2 || INX !== 4'd0) begin
            miscompares++; $display("FAIL resume_fetch got playing=%b addr=%0d inx=%0d want 1/2/0", PLAYING, ROM_ADDR, INX);
        end
        tick();
        vectors++; if (INX !== 4'd0) begin miscompares++; $display("FAIL resume_load_inx got %0d want 0", INX); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (INX !== 4'd9 || ROM_ADDR !== 8'd2) begin miscompares++; $display("FAIL resume_hold k=%0d got inx=%0d addr=%0d want 9/2", k, INX, ROM_ADDR); end
        end
        tick();
        vectors++; if (ROM_ADDR !== 8'd3) begin miscompares++; $display("FAIL resume_advance got %0d want 3", ROM_ADDR); end
        pulse_stop();
    endtask

    task automatic test_simultaneous;
        pulse_play();
        repeat (15) tick();
        PAUSE = 1'b1;
        STOP = 1'b1;
        tick();
        PAUSE = 1'b0;
        STOP = 1'b0;
        vectors++; if (PLAYING !== 1'b0 || ROM_ADDR !== 8'd0 || INX !== 4'd0) begin
            miscompares++; $display("FAIL stop_over_pause got playing=%b addr=%0d inx=%0d want 0/0/0", PLAYING, ROM_ADDR, INX);
        end

        pulse_play();
        repeat (23) tick();
        vectors++; if (SONG_END !== 1'b1) begin miscompares++; $display("FAIL expiry_song_end got %b want 1", SONG_END); end
        PAUSE = 1'b1;
        #1;
        vectors++; if (SONG_END !== 1'b0) begin miscompares++; $display("FAIL pause_expiry_song_end got %b want 0", SONG_END); end
        tick();
        PAUSE = 1'b0;
        vectors++; if (PLAYING !== 1'b0 || ROM_ADDR !== 8'd3 || INX !== 4'd0) begin
            miscompares++; $display("FAIL pause_expiry got playing=%b addr=%0d inx=%0d want 0/3/0", PLAYING, ROM_ADDR, INX);
        end
        tick();
        vectors++; if (SONG_END !== 1'b0) begin miscompares++; $display("FAIL paused_song_end got %b want 0", SONG_END); end
        pulse_play();
        vectors++; if (PLAYING !== 1'b1 || ROM_ADDR !== 8'd3) begin
            miscompares++; $display("FAIL pause_expiry_resume got playing=%b addr=%0d want 1/3", PLAYING, ROM_ADDR);
        end
        pulse_stop();

        pulse_play();
        repeat (23) tick();
        STOP = 1'b1;
        #1;
        vectors++; if (SONG_END !== 1'b0) begin miscompares++; $display("FAIL stop_expiry_song_end got %b want 0", SONG_END); end
        tick();
        STOP = 1'b0;
        vectors++; if (PLAYING !== 1'b0 || ROM_ADDR !== 8'd0) begin
            miscompares++; $display("FAIL stop_expiry got playing=%b addr=%0d want 0/0", PLAYING, ROM_ADDR);
        end
    endtask

    task automatic test_manual;
        pulse_play();
        repeat (9) tick();
        MODE = 1'b1;
        KEY_INX = 4'd12;
        tick();
        vectors++; if (INX !== 4'd12) begin miscompares++; $display("FAIL manual_inx got %0d want 12", INX); end
        vectors++; if (PLAYING !== 1'b0 || ROM_ADDR !== 8'd0) begin
            miscompares++; $display("FAIL manual_abort got playing=%b addr=%0d want 0/0", PLAYING, ROM_ADDR);
        end
        KEY_INX = 4'd3;
        PLAY = 1'b1;
        tick();
        PLAY = 1'b0;
        vectors++; if (INX !== 4'd3 || PLAYING !== 1'b0) begin
            miscompares++; $display("FAIL manual_play_ignored got inx=%0d playing=%b want 3/0", INX, PLAYING);
        end
        MODE = 1'b0;
        KEY_INX = 4'd0;
        tick();
        vectors++; if (INX !== 4'd0 || PLAYING !== 1'b0) begin
            miscompares++; $display("FAIL manual_exit got inx=%0d playing=%b want 0/0", INX, PLAYING);
        end
        tick();
        vectors++; if (PLAYING !== 1'b0) begin miscompares++; $display("FAIL manual_exit_idle got %b want 0", PLAYING); end
        pulse_play();
        vectors++; if (PLAYING !== 1'b1 || ROM_ADDR !== 8'd0) begin
            miscompares++; $display("FAIL manual_restart got playing=%b addr=%0d want 1/0", PLAYING, ROM_ADDR);
        end
        repeat (2) tick();
        vectors++; if (INX !== 4'd5) begin miscompares++; $display("FAIL manual_restart_inx got %0d want 5", INX); end
        pulse_stop();
    endtask

    task automatic test_async_reset;
        pulse_play();
        repeat (15) tick();
        vectors++; if (INX !== 4'd9 || ROM_ADDR !== 8'd2) begin
            miscompares++; $display("FAIL areset_pre got inx=%0d addr=%0d want 9/2", INX, ROM_ADDR);
        end
        #2;
        RST_N = 1'b0;
        #1;
        vectors++; if (INX !== 4'd0) begin miscompares++; $display("FAIL areset_inx got %0d want 0", INX); end
        vectors++; if (ROM_ADDR !== 8'd0) begin miscompares++; $display("FAIL areset_addr got %0d want 0", ROM_ADDR); end
        vectors++; if (PLAYING !== 1'b0) begin miscompares++; $display("FAIL areset_playing got %b want 0", PLAYING); end
        #1;
        RST_N = 1'b1;
        tick();
        vectors++; if (PLAYING !== 1'b0 || INX !== 4'd0) begin
            miscompares++; $display("FAIL areset_after got playing=%b inx=%0d want 0/0", PLAYING, INX);
        end
    endtask

    initial begin
        test_reset();
        test_basic_play();
        test_loop();
        test_pause_resume();
        test_simultaneous();
        test_manual();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Playback controller for the music-player datapath. Steps a note-index ROM at a fixed beat rate and drives the 4-bit tone index INX.
- INX feeds the tone-table / divider chain and the note-code display mapper (INX 0 = rest; 1..7 low octave; 8..15 high octave).
- Arbitrates the INX source between automatic song playback and manual key input. Provides play / pause / stop / loop control.

Parameters:
- ADDR_W, 8, width of note-ROM address.
- LAST_ADDR, 138, address of the final note of the song (must be < 2**ADDR_W).
- BEAT_DIV, 4, CLK cycles each note is held in HOLD state (>= 1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- MODE  in  1  0 = auto playback, 1 = manual key play.
- KEY_INX  in  4  manual tone index (0 = no key).
- PLAY  in  1  one-cycle pulse: start or resume playback.
- PAUSE  in  1  one-cycle pulse: pause playback.
- STOP  in  1  one-cycle pulse: stop and rewind.
- LOOP  in  1  level; 1 = wrap to address 0 at song end.
- ROM_ADDR  out  ADDR_W  note-ROM address (registered, = pointer).
- ROM_DATA  in  4  note-ROM read data, valid 1 cycle after ROM_ADDR changes (synchronous ROM).
- INX  out  4  tone index to tone table and code mapper.
- PLAYING  out  1  1 in FETCH / LOAD / HOLD.
- SONG_END  out  1  one-cycle pulse when the last note's beat expires.

Behaviour:
- Reset (async, RST_N=0): state IDLE, pointer=0, ROM_ADDR=0, INX=0, PLAYING=0, SONG_END=0, beat counter=0.
- States: IDLE, FETCH, LOAD, HOLD, PAUSED.
- IDLE: INX=0. PLAY -> FETCH (pointer unchanged).
- FETCH: ROM_ADDR=pointer presented for 1 cycle; INX holds previous value (no glitch) -> LOAD.
- LOAD: INX<=ROM_DATA; beat counter<=0 -> HOLD.
- HOLD: counter increments each cycle. At count BEAT_DIV-1:
  - pointer<LAST_ADDR: pointer+1 -> FETCH.
  - pointer==LAST_ADDR: SONG_END=1 that cycle.
    - LOOP=1: pointer<=0 -> FETCH.
    - LOOP=0: pointer<=0, INX<=0 -> IDLE.
- Note period: BEAT_DIV+2 cycles; INX changes exactly once per note, in LOAD.
- Durations are encoded by repeated ROM entries; no duration field.
- PAUSE in FETCH / LOAD / HOLD -> PAUSED: INX<=0, pointer held, counter cleared.
- PAUSED: PLAY -> FETCH, re-fetching the current note from the start of its beat. PAUSE is ignored.
- STOP in any state -> IDLE: pointer<=0, INX<=0, counter<=0.
- Priority among simultaneous control pulses: STOP > PAUSE > PLAY.
  - PAUSE on the expiry cycle of HOLD wins: no advance, no SONG_END.
  - STOP on the last beat suppresses SONG_END.
  - PLAY in FETCH / LOAD / HOLD is ignored.
- LOOP is sampled only at the last-beat expiry.
- MODE=1 (manual):
  - Auto FSM forced to IDLE, pointer<=0.
  - INX<=KEY_INX registered every cycle (1-cycle latency).
  - PLAY / PAUSE / STOP ignored; PLAYING=0.
- MODE 1->0: INX<=0 next cycle; FSM remains in IDLE until PLAY.
- MODE 0->1 mid-song: playback aborted; next cycle INX=KEY_INX.
- Pointer arithmetic: ADDR_W bits, unsigned. Never exceeds LAST_ADDR (explicit compare, no natural overflow).

Decomposition:
- Shared package music_pkg:
  - state enum (IDLE, FETCH, LOAD, HOLD, PAUSED).
  - INX_W=4, REST_INX=4'd0, HIGH_OCT_BASE=4'd8.
  - Also used by the tone table and code mapper.
- One natural sub-module: beat_timer (counter with clear, count-enable and terminal-count output, width $clog2(BEAT_DIV)+1). Everything else stays in music_sequencer.

Test Plan:
- Reset and basic play (LAST_ADDR=3, BEAT_DIV=4, ROM={5,5,9,0}): pulse PLAY -> INX sequence 5,5,9,0, each held 6 cycles; SONG_END pulses once; returns to IDLE with INX=0, ROM_ADDR=0.
- Loop: same ROM, LOOP=1 -> after note at address 3, ROM_ADDR wraps to 0 and INX=5 again; SONG_END pulses once per pass; PLAYING stays 1.
- Pause/resume: PAUSE in HOLD of address 2 -> INX=0 next cycle, ROM_ADDR holds 2; PLAY 10 cycles later -> INX=9 after 2 cycles, held full 4-cycle beat.
- Simultaneous events: PAUSE and STOP on the same cycle -> IDLE, pointer 0; PAUSE on the beat-expiry cycle of address 3 -> PAUSED, no SONG_END, pointer still 3.
- Manual arbitration: mid-song set MODE=1, KEY_INX=12 -> INX=12 one cycle later, PLAYING=0; MODE=0 -> INX=0, PLAY restarts from address 0.
- Async reset mid-HOLD: drop RST_N off-edge -> INX, ROM_ADDR, PLAYING cleared immediately without a clock edge.
